// File: rtl/pipe_alu_regfile.sv
// Two-stage register-file/ALU datapath: issue reads operands (with retire forwarding),
// execute computes result and flags, retirement writes back ALU result or external data.
module pipe_alu_regfile #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int R0_ZERO = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    alu_op,
  input  logic [AW-1:0] r_addr_a,
  input  logic [AW-1:0] r_addr_b,
  input  logic [AW-1:0] w_addr,
  input  logic          write_reg,
  input  logic          write_f,
  input  logic [DW-1:0] w_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] f,
  output logic          zf,
  output logic          of,
  output logic          cf,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);
  localparam int NREG = 2**AW;
  localparam int SW   = $clog2(DW);

  logic [DW-1:0] regs [NREG];

  logic          e_valid;
  logic [3:0]    e_op;
  logic [DW-1:0] e_a, e_b, e_wdata;
  logic [AW-1:0] e_waddr;
  logic          e_wreg, e_wf;

  logic          issue, retire, wb_en;
  logic [DW-1:0] wb_val, op_a, op_b, f_c;
  logic [DW:0]   sum, diff;
  logic [SW-1:0] sh;
  logic          of_c, cf_c;

  assign in_ready  = !e_valid || out_ready;
  assign issue     = in_valid && in_ready;
  assign retire    = e_valid && out_ready;
  assign out_valid = e_valid;
  assign f         = f_c;
  assign dbg_data  = regs[dbg_addr];

  assign wb_en  = retire && e_wreg && !((R0_ZERO != 0) && (e_waddr == '0));
  assign wb_val = e_wf ? f_c : e_wdata;

  // Operand read sees the write retiring on the same edge; r0 pinned to zero when enabled.
  always_comb begin
    op_a = regs[r_addr_a];
    if (wb_en && (e_waddr == r_addr_a)) op_a = wb_val;
    if ((R0_ZERO != 0) && (r_addr_a == '0)) op_a = '0;
    op_b = regs[r_addr_b];
    if (wb_en && (e_waddr == r_addr_b)) op_b = wb_val;
    if ((R0_ZERO != 0) && (r_addr_b == '0)) op_b = '0;
  end

  assign sum  = {1'b0, e_a} + {1'b0, e_b};
  assign diff = {1'b0, e_a} - {1'b0, e_b};
  assign sh   = e_a[SW-1:0];

  always_comb begin
    f_c  = '0;
    of_c = 1'b0;
    cf_c = 1'b0;
    case (e_op)
      4'd0:  f_c = e_a & e_b;
      4'd1:  f_c = e_a | e_b;
      4'd2:  f_c = e_a ^ e_b;
      4'd3:  f_c = ~(e_a | e_b);
      4'd4: begin
        f_c  = sum[DW-1:0];
        cf_c = sum[DW];
        of_c = (e_a[DW-1] == e_b[DW-1]) && (sum[DW-1] != e_a[DW-1]);
      end
      4'd5: begin
        f_c  = diff[DW-1:0];
        cf_c = diff[DW];
        of_c = (e_a[DW-1] != e_b[DW-1]) && (diff[DW-1] != e_a[DW-1]);
      end
      4'd6:  f_c = {{(DW-1){1'b0}}, ($signed(e_a) < $signed(e_b))};
      4'd7:  f_c = {{(DW-1){1'b0}}, (e_a < e_b)};
      4'd8:  f_c = e_b << sh;
      4'd9:  f_c = e_b >> sh;
      4'd10: f_c = $signed(e_b) >>> sh;
      4'd11: f_c = e_b;
      default: f_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid <= 1'b0;
      e_op    <= '0;
      e_a     <= '0;
      e_b     <= '0;
      e_wdata <= '0;
      e_waddr <= '0;
      e_wreg  <= 1'b0;
      e_wf    <= 1'b0;
      zf      <= 1'b0;
      of      <= 1'b0;
      cf      <= 1'b0;
    end else begin
      if (issue) begin
        e_valid <= 1'b1;
        e_op    <= alu_op;
        e_a     <= op_a;
        e_b     <= op_b;
        e_wdata <= w_data;
        e_waddr <= w_addr;
        e_wreg  <= write_reg;
        e_wf    <= write_f;
      end else if (retire) begin
        e_valid <= 1'b0;
      end
      if (retire) begin
        zf <= (f_c == '0);
        of <= of_c;
        cf <= cf_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[e_waddr] <= wb_val;
    end
  end
endmodule
